imm_encode_unit: RTL and testbench
==================================

// Module: imm_encode_unit
// PURPOSE
//  Inverse of the immediate select/extend path: takes a 32-bit value and packs it into an immediate
//  field for a requested format, or searches for the narrowest format that represents it exactly.
//  Sits in the instruction builder/test-generator path. Feeding imm_field back through the
//  extend path with imm_select must reproduce value whenever fit=1.
//  Valid/ready handshake on both sides; multi-cycle FSM search in AUTO mode.
// PARAMETERS
//  DataSize  32      width of value operand
//  AutoMode  3'b111  mode code requesting narrowest-format search
// PORTS
//  clk         input   1   single clock, rising edge
//  rst         input   1   reset, asynchronous, active-low
//  in_valid    input   1   request present
//  in_ready    output  1   unit can accept (high only in IDLE)
//  value       input   32  value to encode
//  mode        input   3   000 5ZE, 001 15SE, 010 15ZE, 011 20SE, 100 14SE, 101 24SE, 111 AUTO
//  out_valid   output  1   result present (DONE state)
//  out_ready   input   1   consumer takes result
//  imm_field   output  24  packed field, LSB-aligned, unused upper bits 0
//  imm_select  output  3   format code chosen (111 if AUTO found none)
//  fit         output  1   1 = value exactly representable in imm_select format
// BEHAVIOUR
//  Reset (rst=0, any time, async): state=IDLE; out_valid=0, imm_field=0, imm_select=0, fit=0;
//   in-flight request discarded; in_ready=1 after rst deasserts.
//  Fit rules: nZE fits iff value[31:n]==0; nSE fits iff value[31:n-1] all equal.
//   Packed field = value[n-1:0] when fit, else 0.
//  FSM IDLE -> CHECK -> DONE -> IDLE.
//   IDLE: in_ready=1; in_valid=1 at edge -> latch value/mode, idx=0, go CHECK.
//   CHECK: tests one candidate per cycle. Fixed mode: candidate=mode, one cycle -> DONE.
//    AUTO: order 000,100,001,010,011,101 (5ZE,14SE,15SE,15ZE,20SE,24SE); first fit -> DONE;
//    after 6th miss -> DONE with fit=0, imm_select=111, imm_field=0.
//   DONE: out_valid=1, outputs stable until out_ready=1 at edge -> IDLE. in_ready=0 in DONE
//    (no accept on the completing cycle; next accept earliest one cycle later).
//  Latency accept->out_valid: fixed mode 2 cycles; AUTO 1+k cycles, k = position of first fit (1..6).
//  Invalid mode 110: one CHECK cycle, fit=0, imm_select=110, imm_field=0.
//  Value 0 in AUTO -> 5ZE hit on first check. Negative values never fit ZE formats.
//  Inputs sampled only on the accept edge; changes to value/mode afterwards have no effect.
//  out_ready held high before DONE has no effect; out_valid never drops without out_ready.
// STRUCTURE
//  Package imm_fmt_pkg: format code localparams (IMM5ZE..IMM24SE, AUTO), field width per code,
//   SE/ZE flag per code, AUTO search-order table, FSM state encoding.
//  Sub-module imm_fit_check (combinational): value, code -> fit, packed field; one instance,
//   driven by latched value and current candidate code. All state/regs in imm_encode_unit.
// TESTING
//  Fixed 15SE, value=32'hFFFF_C000 -> out_valid at +2, fit=1, imm_select=001, imm_field=24'h004000.
//  AUTO, value=32'h0000_4000 -> 5ZE,14SE,15SE miss, 15ZE hit: fit=1, imm_select=010, field=24'h004000, latency 5.
//  AUTO, value=32'h0100_0000 -> all 6 miss: fit=0, imm_select=111, field=0, latency 7.
//  AUTO value=32'd17 -> 5ZE first check, latency 2; hold out_ready=0 5 cycles -> outputs stable, in_ready=0.
//  Assert rst low during AUTO CHECK (idx=3) -> all outputs 0 immediately, IDLE, next request encodes correctly.
//  Random value/mode round-trip: when fit=1, extend(imm_field,imm_select)==value; mode 110 -> fit=0.

Source files
------------

// File: rtl/imm_fmt_pkg.sv
// Immediate format definitions shared by the encoder: format codes, field widths,
// signedness, the AUTO search order and the encoder FSM states.
package imm_fmt_pkg;

    localparam int DataSize   = 32;
    localparam int FieldWidth = 24;
    localparam int AutoSteps  = 6;

    typedef logic [2:0] imm_code_t;

    localparam imm_code_t IMM5ZE  = 3'b000;
    localparam imm_code_t IMM15SE = 3'b001;
    localparam imm_code_t IMM15ZE = 3'b010;
    localparam imm_code_t IMM20SE = 3'b011;
    localparam imm_code_t IMM14SE = 3'b100;
    localparam imm_code_t IMM24SE = 3'b101;
    localparam imm_code_t IMM_BAD = 3'b110;
    localparam imm_code_t AUTO    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Zero width marks a code with no field (invalid or AUTO): nothing fits it.
    function automatic int field_width(imm_code_t code);
        case (code)
            IMM5ZE:  return 5;
            IMM15SE: return 15;
            IMM15ZE: return 15;
            IMM20SE: return 20;
            IMM14SE: return 14;
            IMM24SE: return 24;
            default: return 0;
        endcase
    endfunction

    function automatic logic is_signed(imm_code_t code);
        return (code == IMM15SE) || (code == IMM20SE) ||
               (code == IMM14SE) || (code == IMM24SE);
    endfunction

    // Narrowest-first search order used in AUTO mode.
    function automatic imm_code_t auto_code(logic [2:0] idx);
        case (idx)
            3'd0:    return IMM5ZE;
            3'd1:    return IMM14SE;
            3'd2:    return IMM15SE;
            3'd3:    return IMM15ZE;
            3'd4:    return IMM20SE;
            default: return IMM24SE;
        endcase
    endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational fit test: decides whether value is exactly representable in the
// given format and produces the LSB-aligned packed field (zero when it does not fit).
module imm_fit_check
    import imm_fmt_pkg::*;
(
    input  logic [DataSize-1:0]   value,
    input  imm_code_t             code,
    output logic                  fit,
    output logic [FieldWidth-1:0] field
);

    always_comb begin
        int  width;
        logic se;
        logic ok;
        // NOTE: every output gets a default before any conditional update, so no latch is inferred.
        width = field_width(code);
        se    = is_signed(code);
        ok    = (width != 0);
        field = '0;

        // SE: all bits from n-1 upward must match the sign; ZE: all bits from n upward must be 0.
        for (int i = 0; i < DataSize; i++) begin
            if (se) begin
                if (i >= width - 1 && value[i] != value[DataSize-1]) ok = 1'b0;
            end else begin
                if (i >= width && value[i]) ok = 1'b0;
            end
        end

        for (int i = 0; i < FieldWidth; i++) begin
            if (ok && i < width) field[i] = value[i];
        end
        fit = ok;
    end

endmodule

// File: rtl/imm_encode_unit.sv
// Immediate encoder: packs a 32-bit value into a requested immediate format, or in AUTO
// mode searches one candidate per cycle for the narrowest format that holds it exactly.
module imm_encode_unit
    import imm_fmt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DataSize-1:0]   value,
    input  logic [2:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FieldWidth-1:0] imm_field,
    output logic [2:0]            imm_select,
    output logic                  fit
);

    state_t                state_q, state_d;
    logic [DataSize-1:0]   value_q;
    imm_code_t             mode_q;
    logic [2:0]            idx_q;
    logic [FieldWidth-1:0] field_q;
    imm_code_t             select_q;
    logic                  fit_q;

    imm_code_t             cand_code;
    logic                  chk_fit;
    logic [FieldWidth-1:0] chk_field;
    logic                  last_cand;

    assign cand_code = (mode_q == AUTO) ? auto_code(idx_q) : mode_q;
    assign last_cand = (mode_q != AUTO) || chk_fit || (idx_q == 3'(AutoSteps - 1));

    imm_fit_check u_fit_check (
        .value (value_q),
        .code  (cand_code),
        .fit   (chk_fit),
        .field (chk_field)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)  state_d = ST_CHECK;
            ST_CHECK: if (last_cand) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            // NOTE: the latched operands are reset too, so the checker never sees X after reset.
            value_q  <= '0;
            mode_q   <= IMM5ZE;
            idx_q    <= '0;
            field_q  <= '0;
            select_q <= IMM5ZE;
            fit_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid) begin
                value_q <= value;
                mode_q  <= mode;
                idx_q   <= '0;
            end
            if (state_q == ST_CHECK) begin
                idx_q <= idx_q + 3'd1;
                if (last_cand) begin
                    // An exhausted AUTO search reports the AUTO code itself with no fit.
                    if (mode_q == AUTO && !chk_fit) begin
                        field_q  <= '0;
                        select_q <= AUTO;
                        fit_q    <= 1'b0;
                    end else begin
                        field_q  <= chk_field;
                        select_q <= cand_code;
                        fit_q    <= chk_fit;
                    end
                end
            end
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign imm_field  = field_q;
    assign imm_select = select_q;
    assign fit        = fit_q;

endmodule

// File: tb/tb_imm_encode_unit.sv
// Self-checking bench for imm_encode_unit: directed cases plus randomized requests
// compared against an arithmetic reference model of the immediate formats.
module tb_imm_encode_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] value = '0;
    logic [2:0]  mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] imm_field;
    logic [2:0]  imm_select;
    logic        fit;

    int n_tests = 0;
    int n_fail  = 0;

    imm_encode_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .value      (value),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .imm_field  (imm_field),
        .imm_select (imm_select),
        .fit        (fit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Format table: width and signedness per code; width 0 means no such format.
    function automatic void fmt_info(input logic [2:0] code, output int n, output bit se);
        case (code)
            3'd0: begin n = 5;  se = 0; end
            3'd1: begin n = 15; se = 1; end
            3'd2: begin n = 15; se = 0; end
            3'd3: begin n = 20; se = 1; end
            3'd4: begin n = 14; se = 1; end
            3'd5: begin n = 24; se = 1; end
            default: begin n = 0; se = 0; end
        endcase
    endfunction

    function automatic bit fits_fmt(input logic [31:0] v, input logic [2:0] code);
        int n; bit se;
        longint uv, sv, lim;
        fmt_info(code, n, se);
        if (n == 0) return 0;
        uv = longint'({32'b0, v});
        sv = longint'($signed(v));
        if (se) begin
            lim = longint'(1) << (n - 1);
            return (sv >= -lim) && (sv < lim);
        end
        return uv < (longint'(1) << n);
    endfunction

    function automatic void model(input logic [31:0] v, input logic [2:0] m,
                                  output bit e_fit, output logic [23:0] e_field,
                                  output logic [2:0] e_sel, output int e_lat);
        int order[6] = '{0, 4, 1, 2, 3, 5};
        int n; bit se;
        e_fit = 0; e_field = '0; e_sel = m; e_lat = 2;
        if (m == 3'd7) begin
            e_sel = 3'd7;
            e_lat = 7;
            for (int k = 0; k < 6; k++) begin
                if (fits_fmt(v, 3'(order[k]))) begin
                    e_sel = 3'(order[k]);
                    e_lat = 2 + k;
                    break;
                end
            end
        end
        e_fit = fits_fmt(v, e_sel);
        if (e_fit) begin
            fmt_info(e_sel, n, se);
            e_field = 24'(longint'({32'b0, v}) % (longint'(1) << n));
        end
    endfunction

    function automatic logic [31:0] extend(input logic [23:0] f, input logic [2:0] code);
        int n; bit se;
        longint x;
        fmt_info(code, n, se);
        x = longint'({40'b0, f});
        if (se && f[n-1]) x = x - (longint'(1) << n);
        return 32'(x);
    endfunction

    // One request: accept on a posedge, measure latency, hold, then release the result.
    task automatic run(input logic [31:0] v, input logic [2:0] m, input int hold, input bit early);
        bit e_fit; logic [23:0] e_field; logic [2:0] e_sel; int e_lat;
        int lat;
        model(v, m, e_fit, e_field, e_sel, e_lat);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        value     = v;
        mode      = m;
        out_ready = early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        value    = $urandom;
        mode     = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("fit", 32'(fit), 32'(e_fit));
        check("imm_select", 32'(imm_select), 32'(e_sel));
        check("imm_field", 32'(imm_field), 32'(e_field));
        check("in_ready_done", 32'(in_ready), 32'd0);
        if (fit) check("round_trip", extend(imm_field, imm_select), v);
        if (!early) begin
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_ready", 32'(in_ready), 32'd0);
                check("hold_field", 32'(imm_field), 32'(e_field));
                check("hold_select", 32'(imm_select), 32'(e_sel));
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("released", 32'(out_valid), 32'd0);
        check("idle_again", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int m;
        logic [31:0] v;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_field", 32'(imm_field), 32'd0);
        check("rst_select", 32'(imm_select), 32'd0);
        check("rst_fit", 32'(fit), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run(32'hFFFF_C000, 3'b001, 0, 0);
        run(32'h0000_4000, 3'b111, 0, 0);
        run(32'h0100_0000, 3'b111, 0, 0);
        run(32'h0000_0000, 3'b111, 0, 0);
        run(32'h8000_0000, 3'b010, 0, 0);
        run(32'hFFFF_FFFF, 3'b000, 0, 1);
        run(32'h0000_1234, 3'b110, 0, 0);
        run(32'h007F_FFFF, 3'b101, 0, 0);
        run(32'h0000_0011, 3'b111, 5, 0);

        // Reset in the middle of an AUTO search (candidate index 3).
        @(negedge clk);
        in_valid = 1'b1;
        value    = 32'h0100_0000;
        mode     = 3'b111;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_field", 32'(imm_field), 32'd0);
        check("mid_rst_select", 32'(imm_select), 32'd0);
        check("mid_rst_fit", 32'(fit), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run(32'h0000_4000, 3'b111, 1, 0);

        for (int t = 0; t < 200; t++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            m = $urandom_range(0, 7);
            run(v, 3'(m), $urandom_range(0, 2), bit'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
